spongent_sponge_ctrl: RTL

- Sponge-mode controller for the Spongent hash. It sits directly upstream of the Permute core, which it also drives and reads back.
- Absorb: accepts pre-padded message blocks of RATE_W bits and XORs each into the low rate bits of the STATE_W-bit state. It then starts Permute and captures the result.
- Squeeze: after the last block, emits N_SQUEEZE output blocks of RATE_W bits, with a permutation between consecutive outputs.
- Default sizing is Spongent-88/176/88 (b=264, r=88).

---
 rtl/spongent_sponge_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/spongent_sponge_ctrl.sv
// spongent_sponge_ctrl: sponge absorb/squeeze sequencer driving an external Spongent permutation core
module spongent_sponge_ctrl #(
    parameter int STATE_W   = 264,
    parameter int RATE_W    = 88,
    parameter int N_SQUEEZE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATE_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [RATE_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy,
    output logic [STATE_W-1:0] perm_state_in,
    output logic               perm_en,
    input  logic [STATE_W-1:0] perm_state_out,
    input  logic               perm_rdy
);
    localparam int CW = $clog2(N_SQUEEZE) + 1;
    typedef enum logic [2:0] {IDLE, ABSORB, PERM_ABS, SQUEEZE, PERM_SQ} state_t;
    state_t             st;
    logic [STATE_W-1:0] state_r;
    logic [CW-1:0]      cnt;
    logic               last_r;
    logic               first;
    assign out_data      = state_r[RATE_W-1:0];
    assign perm_state_in = state_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            state_r   <= '0;
            cnt       <= '0;
            last_r    <= 1'b0;
            first     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            perm_en   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (st)
                IDLE, ABSORB: if (in_valid) begin
                    state_r[RATE_W-1:0] <= state_r[RATE_W-1:0] ^ in_data;
                    last_r   <= in_last;
                    first    <= 1'b1;
                    st       <= PERM_ABS;
                    in_ready <= 1'b0;
                    perm_en  <= 1'b1;
                    busy     <= 1'b1;
                end
                PERM_ABS, PERM_SQ: begin
                    first <= 1'b0;
                    // rdy seen in the first cycle is left over from the previous run
                    if (!first && perm_rdy) begin
                        state_r <= perm_state_out;
                        perm_en <= 1'b0;
                        if (st == PERM_SQ || last_r) begin
                            st        <= SQUEEZE;
                            out_valid <= 1'b1;
                            out_last  <= cnt == CW'(N_SQUEEZE - 1);
                        end else begin
                            st       <= ABSORB;
                            in_ready <= 1'b1;
                        end
                    end
                end
                SQUEEZE: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (out_last) begin
                        cnt      <= '0;
                        state_r  <= '0;
                        st       <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        st      <= PERM_SQ;
                        perm_en <= 1'b1;
                        first   <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
